// File: rtl/pipe_reg_d_pkg.sv
// Y86-64 field definitions and shared types for the fetch-to-decode pipeline register.
// The `define block below stands in for the codebase's define.v and adds `SBUB.
`ifndef PIPE_REG_D_DEFINES
`define PIPE_REG_D_DEFINES
`define TRUE          1'b1
`define FALSE         1'b0
`define STAT_BUS      3:0
`define ICODE_BUS     3:0
`define REG_ADDR_BUS  3:0
`define SBUB          4'h0
`define SAOK          4'h1
`define INOP          4'h1
`define IIRMOVQ       4'h3
`define NREG          4'hF
`endif

package pipe_reg_d_pkg;

    typedef logic [`STAT_BUS]     stat_t;
    typedef logic [`ICODE_BUS]    icode_t;
    typedef logic [`REG_ADDR_BUS] reg_addr_t;

    typedef struct packed {
        stat_t       stat;
        icode_t      icode;
        icode_t      ifun;
        reg_addr_t   ra;
        reg_addr_t   rb;
        logic [63:0] valc;
        logic [63:0] valp;
    } d_fields_t;

    localparam d_fields_t BUBBLE_FIELDS = '{
        stat:  `SBUB,
        icode: `INOP,
        ifun:  4'h0,
        ra:    `NREG,
        rb:    `NREG,
        valc:  64'h0,
        valp:  64'h0
    };

    typedef enum logic {
        RUN  = 1'b0,
        HELD = 1'b1
    } hold_state_t;

endpackage

// File: rtl/pipe_reg_d_sat_counter.sv
// Saturating up-counter with synchronous active-low reset and a synchronous clear.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_o <= '0;
        end else if (clr_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != {W{1'b1}})) begin
            cnt_o <= cnt_o + W'(1);
        end
    end

endmodule

// File: rtl/pipe_reg_d.sv
// Fetch-to-decode pipeline register with stall/bubble control, stall watchdog and conflict flag.
// Optional stall/bubble statistics counters are enabled by defining PIPE_REG_D_STATS_EN.
module pipe_reg_d
    import pipe_reg_d_pkg::*;
#(
    parameter int STALL_LIMIT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 D_stall_i,
    input  logic                 D_bubble_i,
    input  logic [`STAT_BUS]     f_stat_i,
    input  logic [`ICODE_BUS]    f_icode_i,
    input  logic [`ICODE_BUS]    f_ifun_i,
    input  logic [`REG_ADDR_BUS] f_rA_i,
    input  logic [`REG_ADDR_BUS] f_rB_i,
    input  logic [63:0]          f_valC_i,
    input  logic [63:0]          f_valP_i,
    output logic [`STAT_BUS]     D_stat_o,
    output logic [`ICODE_BUS]    D_icode_o,
    output logic [`ICODE_BUS]    D_ifun_o,
    output logic [`REG_ADDR_BUS] D_rA_o,
    output logic [`REG_ADDR_BUS] D_rB_o,
    output logic [63:0]          D_valC_o,
    output logic [63:0]          D_valP_o,
    output logic                 stall_timeout_o,
    output logic                 ctl_conflict_o,
    output logic [CNT_W-1:0]     stall_cnt_o,
    output logic [CNT_W-1:0]     bubble_cnt_o
);

    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STALL_LIMIT - 1);

    d_fields_t        d_q;
    hold_state_t      state;
    logic [CNT_W-1:0] run_cnt;

    // Stall beats bubble, so a conflicting request still holds the stage.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            d_q <= BUBBLE_FIELDS;
        end else if (D_stall_i) begin
            d_q <= d_q;
        end else if (D_bubble_i) begin
            d_q <= BUBBLE_FIELDS;
        end else begin
            d_q <= '{stat:  f_stat_i,
                     icode: f_icode_i,
                     ifun:  f_ifun_i,
                     ra:    f_rA_i,
                     rb:    f_rB_i,
                     valc:  f_valC_i,
                     valp:  f_valP_i};
        end
    end

    assign D_stat_o  = d_q.stat;
    assign D_icode_o = d_q.icode;
    assign D_ifun_o  = d_q.ifun;
    assign D_rA_o    = d_q.ra;
    assign D_rB_o    = d_q.rb;
    assign D_valC_o  = d_q.valc;
    assign D_valP_o  = d_q.valp;

    sat_counter #(.W(CNT_W)) u_run_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (D_stall_i),
        .clr_i   (!D_stall_i),
        .cnt_o   (run_cnt)
    );

    // The run counter still reads 0 on the first stalled edge, so the limit check must not depend on state.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state           <= RUN;
            stall_timeout_o <= 1'b0;
            ctl_conflict_o  <= 1'b0;
        end else begin
            case (state)
                RUN:  if (D_stall_i)  state <= HELD;
                HELD: if (!D_stall_i) state <= RUN;
            endcase
            if (D_stall_i && (run_cnt == LIMIT_M1)) begin
                stall_timeout_o <= 1'b1;
            end
            if (D_stall_i && D_bubble_i) begin
                ctl_conflict_o <= 1'b1;
            end
        end
    end

`ifdef PIPE_REG_D_STATS_EN
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (D_stall_i),
        .clr_i   (1'b0),
        .cnt_o   (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (D_bubble_i && !D_stall_i),
        .clr_i   (1'b0),
        .cnt_o   (bubble_cnt_o)
    );
`else
    assign stall_cnt_o  = '0;
    assign bubble_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_reg_d.sv
// Self-checking bench for pipe_reg_d: directed test-plan sequences then randomized control traffic.
// Expected values come from a cycle-level behavioural model of the stage.
module tb_pipe_reg_d;
    import pipe_reg_d_pkg::*;

    localparam int LIMIT = 4;
    localparam int CW    = 32;

    logic          clk = 1'b0;
    logic          rst_n, stall, bubble;
    logic [3:0]    f_stat, f_icode, f_ifun, f_ra, f_rb;
    logic [63:0]   f_valc, f_valp;
    logic [3:0]    d_stat, d_icode, d_ifun, d_ra, d_rb;
    logic [63:0]   d_valc, d_valp;
    logic          timeout, conflict;
    logic [CW-1:0] stall_cnt, bubble_cnt;

    int checkCount = 0;
    int failCount  = 0;

    // Reference model state
    logic [3:0]  m_stat, m_icode, m_ifun, m_ra, m_rb;
    logic [63:0] m_valc, m_valp;
    bit          m_timeout, m_conflict;
    int          m_streak, m_stalls, m_bubbles;

    pipe_reg_d #(.STALL_LIMIT(LIMIT), .CNT_W(CW)) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .D_stall_i       (stall),
        .D_bubble_i      (bubble),
        .f_stat_i        (f_stat),
        .f_icode_i       (f_icode),
        .f_ifun_i        (f_ifun),
        .f_rA_i          (f_ra),
        .f_rB_i          (f_rb),
        .f_valC_i        (f_valc),
        .f_valP_i        (f_valp),
        .D_stat_o        (d_stat),
        .D_icode_o       (d_icode),
        .D_ifun_o        (d_ifun),
        .D_rA_o          (d_ra),
        .D_rB_o          (d_rb),
        .D_valC_o        (d_valc),
        .D_valP_o        (d_valp),
        .stall_timeout_o (timeout),
        .ctl_conflict_o  (conflict),
        .stall_cnt_o     (stall_cnt),
        .bubble_cnt_o    (bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, observed, expected);
        end
    endtask

    task automatic loadBubble();
        m_stat = 4'h0; m_icode = 4'h1; m_ifun = 4'h0;
        m_ra = 4'hF; m_rb = 4'hF; m_valc = 64'h0; m_valp = 64'h0;
    endtask

    // One clock edge of the stage as described in plain terms.
    task automatic modelEdge();
        if (!rst_n) begin
            loadBubble();
            m_timeout = 0; m_conflict = 0;
            m_streak = 0; m_stalls = 0; m_bubbles = 0;
        end else if (stall) begin
            m_streak++;
            m_stalls++;
            if (m_streak >= LIMIT) m_timeout = 1;
            if (bubble) m_conflict = 1;
        end else begin
            m_streak = 0;
            if (bubble) begin
                loadBubble();
                m_bubbles++;
            end else begin
                m_stat = f_stat; m_icode = f_icode; m_ifun = f_ifun;
                m_ra = f_ra; m_rb = f_rb; m_valc = f_valc; m_valp = f_valp;
            end
        end
    endtask

    task automatic checkAll();
        logic [CW-1:0] expStall, expBubble;
`ifdef PIPE_REG_D_STATS_EN
        expStall  = CW'(m_stalls);
        expBubble = CW'(m_bubbles);
`else
        expStall  = '0;
        expBubble = '0;
`endif
        checkOutput("D_stat",   64'(d_stat),   64'(m_stat));
        checkOutput("D_icode",  64'(d_icode),  64'(m_icode));
        checkOutput("D_ifun",   64'(d_ifun),   64'(m_ifun));
        checkOutput("D_rA",     64'(d_ra),     64'(m_ra));
        checkOutput("D_rB",     64'(d_rb),     64'(m_rb));
        checkOutput("D_valC",   d_valc,        m_valc);
        checkOutput("D_valP",   d_valp,        m_valp);
        checkOutput("timeout",  64'(timeout),  64'(m_timeout));
        checkOutput("conflict", 64'(conflict), 64'(m_conflict));
        checkOutput("stall_cnt",  64'(stall_cnt),  64'(expStall));
        checkOutput("bubble_cnt", 64'(bubble_cnt), 64'(expBubble));
    endtask

    task automatic randomFetch();
        f_stat  = 4'($urandom_range(1, 4));
        f_icode = 4'($urandom);
        f_ifun  = 4'($urandom);
        f_ra    = 4'($urandom);
        f_rb    = 4'($urandom);
        f_valc  = {$urandom, $urandom};
        f_valp  = {$urandom, $urandom};
    endtask

    // Drive controls at the falling edge, advance the model at the rising edge, check 1 ns later.
    task automatic applyStimulus(input logic r, input logic s, input logic b);
        @(negedge clk);
        rst_n = r; stall = s; bubble = b;
        @(posedge clk);
        modelEdge();
        #1;
        checkAll();
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; bubble = 1'b0;
        randomFetch();
        loadBubble();
        m_timeout = 0; m_conflict = 0; m_streak = 0; m_stalls = 0; m_bubbles = 0;

        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("reset_icode_nop", 64'(d_icode), 64'(4'h1));
        checkOutput("reset_stat_sbub", 64'(d_stat),  64'(4'h0));

        // irmovq $0x10, %rbx
        f_stat = 4'h1; f_icode = 4'h3; f_ifun = 4'h0; f_ra = 4'hF; f_rb = 4'h3;
        f_valc = 64'h10; f_valp = 64'h100a;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("irmovq_icode", 64'(d_icode), 64'(4'h3));
        checkOutput("irmovq_valC",  d_valc,       64'h10);

        // Three stalled cycles with changing fetch data, then release
        for (int i = 0; i < 3; i++) begin
            randomFetch();
            applyStimulus(1'b1, 1'b1, 1'b0);
            checkOutput("stall_hold_icode", 64'(d_icode), 64'(4'h3));
        end
        checkOutput("timeout_after_3", 64'(timeout), 64'(1'b0));
        randomFetch();
        applyStimulus(1'b1, 1'b0, 1'b0);

        randomFetch();
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("bubble_valP", d_valp, 64'h0);
        randomFetch();
        applyStimulus(1'b1, 1'b0, 1'b0);

        // Four stalled cycles trip the watchdog on the fourth edge
        for (int i = 0; i < 4; i++) begin
            randomFetch();
            applyStimulus(1'b1, 1'b1, 1'b0);
            checkOutput("timeout_edge", 64'(timeout), 64'(i == 3));
        end
        randomFetch();
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("timeout_sticky", 64'(timeout), 64'(1'b1));

        randomFetch();
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("conflict_set", 64'(conflict), 64'(1'b1));
        randomFetch();
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("conflict_sticky", 64'(conflict), 64'(1'b1));
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("reset_clears_flags", 64'({timeout, conflict}), 64'(2'b00));

        // Counter scenario: 5 stalls, 2 bubbles, 1 stall+bubble
        for (int i = 0; i < 8; i++) begin
            randomFetch();
            applyStimulus(1'b1, i < 5 || i == 7, i == 5 || i == 6 || i == 7);
        end

        for (int i = 0; i < 500; i++) begin
            int roll;
            roll = int'($urandom_range(0, 99));
            randomFetch();
            applyStimulus(roll >= 3, $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 25);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
